// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a register-mapped UART core: programs the baud divisor, then writes each byte
// and its start strobe. Optional watchdog in WAIT enabled by UART_TX_FEEDER_TIMEOUT_EN.
module uart_tx_feeder #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter logic [7:0]  ADDR_BAUD      = 8'h00,
    parameter logic [7:0]  ADDR_TX        = 8'h04,
    parameter logic [7:0]  ADDR_CTRL      = 8'h08,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_in_valid,
    input  logic [7:0]                 io_in_bits,
    output logic                       io_in_ready,
    output logic                       io_core_ren,
    output logic                       io_core_we,
    output logic [7:0]                 io_core_addr,
    output logic [31:0]                io_core_wdata,
    input  logic                       io_core_intr_tx,
    output logic                       io_busy,
    output logic [$clog2(DEPTH):0]     io_level,
    output logic                       io_timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    typedef enum logic [2:0] {
        StBoot, StInitBaud, StIdle, StWriteData, StWriteEn, StWait
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    state_t        r_state;
    logic          r_we;
    logic [7:0]    r_addr;
    logic [31:0]   r_wdata;
    logic          r_intr_prev;
    logic          w_push, w_pop, w_intr_rise;

    assign w_push      = io_in_valid && io_in_ready;
    assign w_pop       = (r_state == StIdle) && (r_level != '0);
    assign w_intr_rise = io_core_intr_tx && !r_intr_prev;

    assign io_in_ready   = (r_level != LVL_FULL);
    assign io_level      = r_level;
    assign io_core_ren   = 1'b0;
    assign io_core_we    = r_we;
    assign io_core_addr  = r_addr;
    assign io_core_wdata = r_wdata;
    assign io_busy       = (r_state != StIdle) || (r_level != '0);

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= io_in_bits;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int unsigned WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] r_wdog;
    logic           r_timeout;
    assign io_timeout = r_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
    assign io_timeout   = 1'b0;
`endif

    // Core outputs are computed from the next state so they are registered alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StBoot;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_intr_prev <= 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_intr_prev <= io_core_intr_tx;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            case (r_state)
                StBoot: begin
                    r_state <= StInitBaud;
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_BAUD;
                    r_wdata <= CLKS_PER_BIT;
                end
                StInitBaud: r_state <= StIdle;
                StIdle: begin
                    if (w_pop) begin
                        r_state <= StWriteData;
                        r_we    <= 1'b1;
                        r_addr  <= ADDR_TX;
                        r_wdata <= {24'h0, r_mem[r_rptr]};
                    end
                end
                StWriteData: begin
                    r_state <= StWriteEn;
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_CTRL;
                    r_wdata <= 32'h1;
                end
                StWriteEn: begin
                    r_state <= StWait;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                end
                StWait: begin
                    if (w_intr_rise) begin
                        r_state <= StIdle;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state   <= StIdle;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
`endif
                    end
                end
                default: r_state <= StBoot;
            endcase
        end
    end
endmodule
